// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path: accumulator width default,
// serializer state type and checksum seed.
package mac_pkg;

    localparam int         ACC_W_DEFAULT = 24;
    localparam logic [7:0] CSUM_INIT     = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2
    } ser_state_t;

endpackage

// File: rtl/mac_hold_reg.sv
// One-entry valid/ready holding register; accepts only when empty, so a
// push and a pop never coincide.
module mac_hold_reg #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         full;
    logic [W-1:0] data_q;
    logic         push;
    logic         pop;

    assign in_ready  = ~full;
    assign out_valid = full;
    assign out_data  = data_q;
    assign push      = in_valid & in_ready;
    assign pop       = full & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // Payload carries no reset; it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/mac_result_serializer.sv
// Serializes each accumulator result into a byte frame: ACC_W/8 data bytes,
// MSB first, followed by an XOR checksum byte, with a one-entry hold buffer.
module mac_result_serializer
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [ACC_W-1:0] acc_data,
    input  logic             acc_valid,
    output logic             acc_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       frame_cnt
);

    localparam int               NB       = ACC_W / 8;
    localparam int               IDX_W    = 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    ser_state_t       state;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       csum;
    logic [ACC_W-1:0] shift_data;

    logic             hold_full;
    logic             hold_push;
    logic             hold_pop;
    logic [ACC_W-1:0] hold_data;

    logic             accept;
    logic             xfer;
    logic             data_xfer;
    logic             csum_done;
    logic             frame_free;
    logic             load_hold;
    logic             load_direct;
    logic             load_frame;
    logic [ACC_W-1:0] load_data;

    assign accept    = acc_valid & acc_ready & ena;
    assign xfer      = byte_valid & byte_ready & ena;
    assign data_xfer = xfer & (state == DATA);
    assign csum_done = xfer & (state == CSUM);

    // A new frame may start from IDLE or on the very edge the checksum leaves,
    // which is what keeps consecutive frames free of bubbles.
    assign frame_free  = (ena & (state == IDLE)) | csum_done;
    assign load_hold   = frame_free & hold_full;
    assign load_direct = frame_free & ~hold_full & accept;
    assign load_frame  = load_hold | load_direct;
    assign load_data   = hold_full ? hold_data : acc_data;

    assign hold_push = accept & ~load_direct;
    assign hold_pop  = load_hold;

    mac_hold_reg #(
        .W (ACC_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (acc_data),
        .in_valid  (hold_push),
        .in_ready  (acc_ready),
        .out_data  (hold_data),
        .out_valid (hold_full),
        .out_ready (hold_pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            csum       <= CSUM_INIT;
            byte_idx   <= '0;
            frame_cnt  <= 8'h00;
        end else begin
            if (csum_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (load_frame) begin
                state      <= DATA;
                byte_out   <= load_data[ACC_W-1 -: 8];
                byte_valid <= 1'b1;
                byte_idx   <= IDX_LAST;
                csum       <= CSUM_INIT;
            end else if (csum_done) begin
                state      <= IDLE;
                byte_valid <= 1'b0;
            end else if (data_xfer) begin
                csum <= csum ^ byte_out;
                if (byte_idx == '0) begin
                    state    <= CSUM;
                    byte_out <= csum ^ byte_out;
                end else begin
                    byte_idx <= byte_idx - 1'b1;
                    byte_out <= shift_data[ACC_W-1 -: 8];
                end
            end
        end
    end

    // Remaining data bytes, already shifted so the next byte sits at the top.
    always_ff @(posedge clk) begin
        if (load_frame) begin
            shift_data <= load_data << 8;
        end else if (data_xfer) begin
            shift_data <= shift_data << 8;
        end
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Randomized and directed bench for mac_result_serializer against a
// queue-based frame model.
module tb_mac_result_serializer;

    localparam int ACC_W = 24;
    localparam int NB    = ACC_W / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic [ACC_W-1:0] acc_data;
    logic             acc_valid;
    logic             acc_ready;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready;
    logic [7:0]       frame_cnt;

    always #5 clk = ~clk;

    mac_result_serializer #(.ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .acc_data   (acc_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_cnt  (frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model: expected byte stream, end-of-frame flags, frames outstanding.
    logic [7:0] exp_q[$];
    bit         last_q[$];
    int         outst = 0;
    logic [7:0] m_cnt = 8'h00;
    logic [7:0] log_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            last_q.delete();
            outst = 0;
            m_cnt = 8'h00;
        end else begin
            bit         m_xfer;
            bit         m_acc;
            logic [7:0] b;
            logic [7:0] x;
            m_xfer = (outst > 0) && byte_ready && ena;
            m_acc  = acc_valid && ena && (outst < 2);
            if (m_xfer) begin
                log_q.push_back(byte_out);
                if (last_q[0]) begin
                    outst--;
                    m_cnt++;
                end
                void'(exp_q.pop_front());
                void'(last_q.pop_front());
            end
            if (m_acc) begin
                x = 8'h00;
                for (int k = 0; k < NB; k++) begin
                    b = 8'(acc_data >> (8 * (NB - 1 - k)));
                    exp_q.push_back(b);
                    last_q.push_back(1'b0);
                    x = x ^ b;
                end
                exp_q.push_back(x);
                last_q.push_back(1'b1);
                outst++;
            end
        end
    end

    always @(negedge clk) begin
        check("byte_valid", byte_valid, (outst > 0));
        check("acc_ready", acc_ready, (outst < 2));
        check("frame_cnt", frame_cnt, m_cnt);
        if (outst > 0) check("byte_out", byte_out, exp_q[0]);
        if (!rst_n) check("byte_out_rst", byte_out, 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [ACC_W-1:0] d);
        acc_valid = 1'b1;
        acc_data  = d;
        cyc();
        acc_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input int n, input logic [63:0] e);
        check({name, "_len"}, log_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < log_q.size()) check(name, log_q[i], e[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", byte_valid, 0);
        check("rst_out", byte_out, 0);
        check("rst_ready", acc_ready, 1);
        check("rst_cnt", frame_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        ena        = 1'b1;
        acc_valid  = 1'b0;
        acc_data   = '0;
        byte_ready = 1'b0;
        reset_pulse();
        cyc();

        // Single frame
        byte_ready = 1'b1;
        log_q.delete();
        start(24'h123456);
        check("first_valid", byte_valid, 1);
        check("first_msb", byte_out, 8'h12);
        repeat (4) cyc();
        check_log("single", 4, 64'h12345670);
        check("single_cnt", frame_cnt, 1);

        // Backpressure on the second byte
        log_q.delete();
        start(24'h123456);
        cyc();
        byte_ready = 1'b0;
        repeat (5) begin
            cyc();
            check("bp_out", byte_out, 8'h34);
            check("bp_valid", byte_valid, 1);
        end
        byte_ready = 1'b1;
        repeat (3) cyc();
        check_log("bp", 4, 64'h12345670);
        check("bp_cnt", frame_cnt, 2);

        // Back-to-back frames through the hold buffer
        log_q.delete();
        acc_valid = 1'b1;
        acc_data  = 24'hFFFFFF;
        cyc();
        acc_data  = 24'h000001;
        cyc();
        acc_valid = 1'b0;
        check("b2b_full_ready", acc_ready, 0);
        cyc();
        check("b2b_full_ready2", acc_ready, 0);
        repeat (6) cyc();
        check_log("b2b", 8, 64'hFFFFFFFF00000101);
        check("b2b_cnt", frame_cnt, 4);

        // Accept coinciding with the checksum transfer
        log_q.delete();
        start(24'h123456);
        repeat (3) cyc();
        acc_valid = 1'b1;
        acc_data  = 24'h0A0B0C;
        cyc();
        acc_valid = 1'b0;
        check("sim_valid", byte_valid, 1);
        check("sim_msb", byte_out, 8'h0A);
        repeat (4) cyc();
        check_log("sim", 8, 64'h123456700A0B0C0D);
        check("sim_cnt", frame_cnt, 6);

        // Enable low mid-frame freezes everything
        log_q.delete();
        start(24'h123456);
        cyc();
        ena       = 1'b0;
        acc_valid = 1'b1;
        acc_data  = 24'h999999;
        repeat (3) begin
            cyc();
            check("ena_out", byte_out, 8'h34);
            check("ena_valid", byte_valid, 1);
            check("ena_cnt", frame_cnt, 6);
        end
        acc_valid = 1'b0;
        ena       = 1'b1;
        repeat (3) cyc();
        check_log("ena", 4, 64'h12345670);
        check("ena_cnt_after", frame_cnt, 7);

        // Reset mid-frame discards the frame
        log_q.delete();
        start(24'h123456);
        cyc();
        cyc();
        reset_pulse();
        log_q.delete();
        start(24'h0A0B0C);
        repeat (4) cyc();
        check_log("rst_new", 4, 64'h0A0B0C0D);
        check("rst_new_cnt", frame_cnt, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            acc_valid  = ($urandom_range(0, 2) != 0);
            acc_data   = ACC_W'($urandom);
            byte_ready = ($urandom_range(0, 9) < 7);
            ena        = ($urandom_range(0, 9) != 0);
            cyc();
        end
        acc_valid  = 1'b0;
        byte_ready = 1'b1;
        ena        = 1'b1;
        repeat (12) cyc();
        check("drain_valid", byte_valid, 0);

        // frame_cnt wraps after 256 frames
        reset_pulse();
        byte_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            start(ACC_W'($urandom));
            repeat (4) cyc();
            if (i == 254) check("wrap_255", frame_cnt, 8'hFF);
        end
        check("wrap_0", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
